// File: rtl/rf_write_arbiter_pkg.sv
// Shared types and constants for the register-file write arbiter.
//   DATA_W / NREG / ADDR_W : register data width, register count, address width
//   state_t                : arbiter FSM states
//   port_t                 : requester identity (used for round-robin history)
//   onehot()               : address -> register clock-enable vector
package rf_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned NREG   = 8;
  localparam int unsigned ADDR_W = $clog2(NREG);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_t;

  // Out-of-range addresses (non power-of-2 NREG) match no bit and yield all zeros.
  function automatic logic [NREG-1:0] onehot(input logic [ADDR_W-1:0] addr);
    logic [NREG-1:0] oh;
    oh = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      if (addr == ADDR_W'(i)) oh[i] = 1'b1;
    end
    return oh;
  endfunction

endpackage

// File: rtl/rf_write_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter, purely combinational.
//   req_i        : request vector, bit 0 = port A, bit 1 = port B
//   last_grant_i : port that won the most recent transfer
//   en_i         : arbitration enable; no grant when low
//   gnt_o        : grant vector, at most one bit set
module rr_arb2
  import rf_pkg::*;
(
  input  logic [1:0] req_i,
  input  port_t      last_grant_i,
  input  logic       en_i,
  output logic [1:0] gnt_o
);

  // On a tie the port that did not win last time is served.
  always_comb begin
    gnt_o = 2'b00;
    if (en_i) begin
      if (req_i == 2'b11) begin
        gnt_o = (last_grant_i == PORT_B) ? 2'b01 : 2'b10;
      end else begin
        gnt_o = req_i;
      end
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Write-side owner of the 8-entry register file: arbitrates port A and port B
// writes round-robin and runs a sequenced bulk clear, one register per cycle.
//   clk, rst_n               : clock, asynchronous active-low reset
//   a_req/a_addr/a_data/a_gnt: port A (execute writeback) request/grant
//   b_req/b_addr/b_data/b_gnt: port B (switch/load path) request/grant
//   clr_req                  : bulk-clear request, sampled only in IDLE
//   busy                     : high while a clear sequence runs
//   rf_data / rf_ce          : registered write data and one-hot clock enables
module rf_write_arbiter
  import rf_pkg::*;
#(
  parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_gnt,
  input  logic              b_req,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_gnt,
  input  logic              clr_req,
  output logic              busy,
  output logic [DATA_W-1:0] rf_data,
  output logic [NREG-1:0]   rf_ce
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  port_t             last_q, last_d;
  logic [DATA_W-1:0] rf_data_q, rf_data_d;
  logic [NREG-1:0]   rf_ce_q, rf_ce_d;
  logic              busy_q, busy_d;
  logic [1:0]        gnt;
  logic              arb_en;

  // Clear request pre-empts arbitration in IDLE; nothing is granted in CLEAR.
  assign arb_en = (state_q == IDLE) && !clr_req;

  rr_arb2 u_arb (
    .req_i        ({b_req, a_req}),
    .last_grant_i (last_q),
    .en_i         (arb_en),
    .gnt_o        (gnt)
  );

  // Grants are forced low while reset is asserted.
  assign a_gnt = gnt[0] & rst_n;
  assign b_gnt = gnt[1] & rst_n;

  // Next-state, write-port and round-robin history logic.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    last_d    = last_q;
    rf_data_d = rf_data_q;
    rf_ce_d   = '0;
    if (state_q == CLEAR) begin
      rf_ce_d   = onehot(clr_cnt_q);
      rf_data_d = CLR_VAL;
      if (clr_cnt_q == ADDR_W'(NREG - 1)) begin
        clr_cnt_d = '0;
        state_d   = IDLE;
      end else begin
        clr_cnt_d = clr_cnt_q + ADDR_W'(1);
      end
    end else if (clr_req) begin
      state_d = CLEAR;
    end else if (gnt[0]) begin
      rf_ce_d   = onehot(a_addr);
      rf_data_d = a_data;
      last_d    = PORT_A;
    end else if (gnt[1]) begin
      rf_ce_d   = onehot(b_addr);
      rf_data_d = b_data;
      last_d    = PORT_B;
    end
    busy_d = (state_d == CLEAR);
  end

  // State and output registers; last_q resets to B so A wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      clr_cnt_q <= '0;
      last_q    <= PORT_B;
      rf_data_q <= '0;
      rf_ce_q   <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      last_q    <= last_d;
      rf_data_q <= rf_data_d;
      rf_ce_q   <= rf_ce_d;
      busy_q    <= busy_d;
    end
  end

  assign rf_data = rf_data_q;
  assign rf_ce   = rf_ce_q;
  assign busy    = busy_q;

endmodule
